// File: rtl/tff_div_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : tff_div_sched_if
// Purpose : request/grant bundle between requesters and the shared divider.
//           Optional TFF_DIV_SCHED_PAUSE_EN adds the hold input.
// Rev     : 1.0
// ============================================================================
interface tff_div_sched_if;
    logic       req0;
    logic       req1;
    logic [2:0] sel0;
    logic [2:0] sel1;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic       gnt0;
    logic       gnt1;
    logic       busy;
    logic       q;
    logic       done;
`ifdef TFF_DIV_SCHED_PAUSE_EN
    logic       hold;
`endif

    modport master (
`ifdef TFF_DIV_SCHED_PAUSE_EN
        output hold,
`endif
        output req0, req1, sel0, sel1, cnt0, cnt1,
        input  gnt0, gnt1, busy, q, done
    );

    modport slave (
`ifdef TFF_DIV_SCHED_PAUSE_EN
        input  hold,
`endif
        input  req0, req1, sel0, sel1, cnt0, cnt1,
        output gnt0, gnt1, busy, q, done
    );
endinterface
`default_nettype wire

// File: rtl/tff_div_sched.sv
`default_nettype none
// ============================================================================
// Module  : tff_div_sched
// Purpose : two-requester round-robin scheduler for a shared toggle-FF divider
//           chain. Optional macro TFF_DIV_SCHED_PAUSE_EN enables bus.hold.
// Rev     : 1.0
// ============================================================================
module tff_div_sched #(
    parameter int STAGES = 4
) (
    input  wire            clk,
    input  wire            rst,
    tff_div_sched_if.slave bus
);

    localparam logic [3:0] C_STAGES  = 4'(STAGES);
    localparam logic [2:0] C_MAX_SEL = 3'(STAGES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q,  last_d;
    logic                gnt0_q,  gnt0_d;
    logic                gnt1_q,  gnt1_d;
    logic [2:0]          sel_q,   sel_d;
    logic [7:0]          cnt_q,   cnt_d;
    logic [7:0]          per_q,   per_d;
    logic [STAGES-1:0]   chain_q, chain_d;

    logic [STAGES-1:0]   w_chain_inc;
    logic                w_carry;
    logic                w_tap;
    logic                w_tick;
    logic                w_hold;
    logic                w_pick1;
    logic                w_owner_req;
    logic [2:0]          w_owner_sel;
    logic [7:0]          w_owner_cnt;

    function automatic logic [2:0] clamp_sel(input logic [2:0] s);
        return ({1'b0, s} >= C_STAGES) ? C_MAX_SEL : s;
    endfunction

`ifdef TFF_DIV_SCHED_PAUSE_EN
    assign w_hold = bus.hold;
`else
    assign w_hold = 1'b0;
`endif

    // Tie goes to whoever was not served last; a lone request always wins.
    assign w_pick1     = bus.req1 && (!bus.req0 || !last_q);
    assign w_owner_req = owner_q ? bus.req1 : bus.req0;
    assign w_owner_sel = clamp_sel(owner_q ? bus.sel1 : bus.sel0);
    assign w_owner_cnt = owner_q ? bus.cnt1 : bus.cnt0;

    // Synchronous cascade: stage k toggles when all lower stages are 1.
    always_comb begin
        w_carry     = 1'b1;
        w_chain_inc = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_chain_inc[k] = chain_q[k] ^ w_carry;
            w_carry        = w_carry & chain_q[k];
        end
    end

    always_comb begin
        w_tap  = 1'b0;
        w_tick = 1'b1;
        for (int k = 0; k < STAGES; k++) begin
            if (sel_q == 3'(k)) begin
                w_tap = chain_q[k];
            end
            if (sel_q >= 3'(k)) begin
                w_tick = w_tick & chain_q[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        chain_d = chain_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_d = w_pick1;
                    gnt0_d  = !w_pick1;
                    gnt1_d  = w_pick1;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!w_owner_req) begin
                    state_d = S_IDLE;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    last_d  = owner_q;
                end else begin
                    sel_d   = w_owner_sel;
                    cnt_d   = w_owner_cnt;
                    per_d   = '0;
                    chain_d = '0;
                    state_d = (w_owner_cnt == 8'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (!w_owner_req) begin
                    state_d = S_IDLE;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    last_d  = owner_q;
                end else if (!w_hold) begin
                    chain_d = w_chain_inc;
                    if (w_tick) begin
                        per_d = per_q + 8'd1;
                        if ((per_q + 8'd1) == cnt_q) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                last_d  = owner_q;
            end
            default: begin
                state_d = S_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            sel_q   <= '0;
            cnt_q   <= '0;
            per_q   <= '0;
            chain_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            chain_q <= chain_d;
        end
    end

    assign bus.gnt0 = gnt0_q;
    assign bus.gnt1 = gnt1_q;
    assign bus.busy = (state_q != S_IDLE);
    assign bus.q    = (state_q == S_RUN) && w_tap;
    assign bus.done = (state_q == S_DONE);

    a_gnt_mutex : assert property (@(posedge clk) disable iff (!rst) !(gnt0_q && gnt1_q));

endmodule
`default_nettype wire

// File: tb/tb_tff_div_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_tff_div_sched
// Purpose : scoreboard bench for tff_div_sched (grant, done, abort events).
// Rev     : 1.0
// ============================================================================
module tb_tff_div_sched;

    localparam int EV_GNT   = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ABORT = 2;

    typedef struct {
        int kind;
        int who;
        int lat;
        int rises;
        int first;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    ev_t  sb[$];

    always #5 clk = ~clk;

    tff_div_sched_if bus ();

    tff_div_sched #(.STAGES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endfunction

    function automatic void push(int k, int who, int lat, int rises, int first);
        ev_t e;
        e.kind = k; e.who = who; e.lat = lat; e.rises = rises; e.first = first;
        sb.push_back(e);
    endfunction

    function automatic void check_event(int k, int who, int lat, int rises, int first);
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual kind=%0d who=%0d expected none", k, who);
        end else begin
            e = sb.pop_front();
            chk("event_kind", k, e.kind);
            chk("event_who", who, e.who);
            if (k == EV_DONE && e.kind == EV_DONE) begin
                chk("run_latency", lat, e.lat);
                chk("q_rises", rises, e.rises);
                chk("q_first_rise", first, e.first);
            end
        end
    endfunction

    // Monitor: turns DUT output transitions into events and scores them.
    initial begin
        logic p_g0, p_g1, p_done, p_q, rise, fall, active;
        int   cyc, rises, first;
        p_g0 = 0; p_g1 = 0; p_done = 0; p_q = 0; active = 0;
        cyc = 0; rises = 0; first = -1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                p_g0 = 0; p_g1 = 0; p_done = 0; p_q = 0; active = 0;
            end else begin
                chk("gnt_onehot", int'(bus.gnt0 & bus.gnt1), 0);
                if (!bus.busy) chk("q_when_idle", int'(bus.q), 0);
                rise = (bus.gnt0 && !p_g0) || (bus.gnt1 && !p_g1);
                fall = (!bus.gnt0 && p_g0) || (!bus.gnt1 && p_g1);
                if (active && !rise) begin
                    cyc++;
                    if (bus.q && !p_q) begin
                        rises++;
                        if (first < 0) first = cyc;
                    end
                end
                if (fall && !p_done) begin
                    check_event(EV_ABORT, p_g1 ? 1 : 0, 0, 0, 0);
                    active = 0;
                end
                if (rise) begin
                    check_event(EV_GNT, bus.gnt1 ? 1 : 0, 0, 0, 0);
                    active = 1; cyc = 0; rises = 0; first = -1;
                end
                if (bus.done) begin
                    check_event(EV_DONE, bus.gnt1 ? 1 : 0, cyc, rises, first);
                    active = 0;
                end
                p_g0 = bus.gnt0; p_g1 = bus.gnt1; p_done = bus.done; p_q = bus.q;
            end
        end
    end

    task automatic wait_gnt(int maxc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.gnt0 || bus.gnt1) && n < maxc);
        if (!(bus.gnt0 || bus.gnt1)) begin
            checks++; errors++;
            $display("FAIL gnt_timeout actual=none expected=grant within %0d cycles", maxc);
        end
    endtask

    task automatic wait_done(int maxc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < maxc);
        if (!bus.done) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=none expected=done within %0d cycles", maxc);
        end
    endtask

    task automatic end_run();
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        chk("idle_after_run", int'(bus.busy), 0);
    endtask

    task automatic check_zero_outputs(string tag);
        chk({tag, "_gnt0"}, int'(bus.gnt0), 0);
        chk({tag, "_gnt1"}, int'(bus.gnt1), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_q"},    int'(bus.q),    0);
        chk({tag, "_done"}, int'(bus.done), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req0 = 0; bus.req1 = 0;
        bus.sel0 = 0; bus.sel1 = 0;
        bus.cnt0 = 0; bus.cnt1 = 0;
`ifdef TFF_DIV_SCHED_PAUSE_EN
        bus.hold = 0;
`endif
        #2 rst = 1'b0;
        #1 check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Basic run: sel=1, cnt=3 -> 12 RUN cycles, q period 4.
        @(posedge clk); #1;
        push(EV_GNT, 0, 0, 0, 0);
        push(EV_DONE, 0, 13, 3, 3);
        bus.sel0 = 3'd1; bus.cnt0 = 8'd3; bus.req0 = 1'b1;
        wait_done(40);
        end_run();

        // Zero-length run: GRANT then DONE, q never rises.
        @(posedge clk); #1;
        push(EV_GNT, 1, 0, 0, 0);
        push(EV_DONE, 1, 1, 0, -1);
        bus.sel1 = 3'd2; bus.cnt1 = 8'd0; bus.req1 = 1'b1;
        wait_done(20);
        end_run();

        // Out-of-range tap clamps to stage 3.
        @(posedge clk); #1;
        push(EV_GNT, 0, 0, 0, 0);
        push(EV_DONE, 0, 17, 1, 9);
        bus.sel0 = 3'd7; bus.cnt0 = 8'd1; bus.req0 = 1'b1;
        wait_done(40);
        end_run();

        // Owner aborts mid-run; pending requester 1 takes over.
        @(posedge clk); #1;
        push(EV_GNT, 0, 0, 0, 0);
        bus.sel0 = 3'd2; bus.cnt0 = 8'd5; bus.req0 = 1'b1;
        bus.sel1 = 3'd0; bus.cnt1 = 8'd2;
        wait_gnt(20);
        repeat (5) @(posedge clk);
        #1;
        push(EV_ABORT, 0, 0, 0, 0);
        push(EV_GNT, 1, 0, 0, 0);
        push(EV_DONE, 1, 5, 2, 2);
        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_gnt0_low", int'(bus.gnt0), 0);
        wait_done(30);
        end_run();

        // Reset in the middle of a run.
        @(posedge clk); #1;
        push(EV_GNT, 1, 0, 0, 0);
        bus.sel1 = 3'd3; bus.cnt1 = 8'd4; bus.req1 = 1'b1;
        wait_gnt(20);
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_zero_outputs("midrun_reset");
        bus.req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", int'(bus.busy), 0);

        // Simultaneous requests after reset alternate, requester 0 first.
        @(posedge clk); #1;
        push(EV_GNT, 0, 0, 0, 0);
        push(EV_DONE, 0, 3, 1, 2);
        push(EV_GNT, 1, 0, 0, 0);
        push(EV_DONE, 1, 5, 1, 3);
        push(EV_GNT, 0, 0, 0, 0);
        push(EV_DONE, 0, 3, 1, 2);
        bus.sel0 = 3'd0; bus.cnt0 = 8'd1;
        bus.sel1 = 3'd1; bus.cnt1 = 8'd1;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        wait_done(20);
        wait_done(20);
        wait_done(20);
        end_run();

`ifdef TFF_DIV_SCHED_PAUSE_EN
        // Five hold cycles stretch an 8-cycle run to 13.
        @(posedge clk); #1;
        push(EV_GNT, 1, 0, 0, 0);
        push(EV_DONE, 1, 14, 2, 3);
        bus.sel1 = 3'd1; bus.cnt1 = 8'd2; bus.req1 = 1'b1;
        wait_gnt(20);
        repeat (4) @(posedge clk);
        #1 bus.hold = 1'b1;
        repeat (5) @(posedge clk);
        #1 bus.hold = 1'b0;
        wait_done(30);
        end_run();
`endif

        repeat (5) @(posedge clk);
        #1 chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
